audio_interval_stats_stream: RTL and testbench

- Streaming, multi-channel successor to the team's array-based interval min/max block.
- Accepts audio frames over a valid/ready stream. Each frame carries one sample per channel.
- Computes per-channel signed min and max over runtime-programmable intervals.
- Emits one result beat per interval over a valid/ready output stream.
- Sits between the audio capture FIFO and the envelope/feature-extraction stage. Needs no sample memory.

---
 rtl/audio_stats_pkg.sv | 65 ++++++
 rtl/audio_interval_stats_stream_chan_min_max.sv | 57 +++++
 rtl/audio_interval_stats_stream.sv | 191 +++++++++++++++++++
 tb/tb_audio_interval_stats_stream.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_stats_pkg.sv
// audio_stats_pkg
//   Shared definitions for audio_interval_stats_stream and its per-channel
//   min/max sub-module:
//     - state_t     : controller state encoding (IDLE / ACCUM / EMIT)
//     - DEF_*       : default parameter values for the top
//     - MAX_*       : widest sample / frame the helper functions handle
//     - extract_ch  : pull channel c out of a packed frame
//     - abs_sat     : two's-complement absolute value, most-negative saturates
//   Optional feature macro used by the top: AUDIO_STATS_PEAK_EN.

package audio_stats_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EMIT  = 2'd2
    } state_t;

    localparam int DEF_SAMPLE_W = 32;
    localparam int DEF_NUM_CH   = 2;
    localparam int DEF_LEN_W    = 16;
    localparam int DEF_IDX_W    = 16;

    // The helpers work on fixed wide containers so one definition serves
    // any SAMPLE_W / NUM_CH instance; callers cast the result back down.
    localparam int MAX_SAMPLE_W = 64;
    localparam int MAX_FRAME_W  = 1024;

    // Channel c of a frame whose channels are w bits wide, channel 0 in the
    // least significant slot. Only the low w bits of the result matter.
    function automatic logic [MAX_SAMPLE_W-1:0] extract_ch(
        input logic [MAX_FRAME_W-1:0] frame,
        input int                     c,
        input int                     w
    );
        logic [MAX_FRAME_W-1:0] shifted;
        shifted = frame >> (c * w);
        return shifted[MAX_SAMPLE_W-1:0];
    endfunction

    // |s| for a w-bit signed value held in the low bits of s. The most
    // negative value has no positive counterpart, so it maps to the most
    // positive value instead of wrapping back to itself.
    function automatic logic [MAX_SAMPLE_W-1:0] abs_sat(
        input logic [MAX_SAMPLE_W-1:0] s,
        input int                      w
    );
        logic [MAX_SAMPLE_W-1:0] sign_bit;
        logic [MAX_SAMPLE_W-1:0] mask;
        logic [MAX_SAMPLE_W-1:0] v;
        logic [MAX_SAMPLE_W-1:0] r;
        sign_bit = MAX_SAMPLE_W'(1) << (w - 1);
        mask     = (sign_bit << 1) - MAX_SAMPLE_W'(1);
        v        = s & mask;
        if ((v & sign_bit) == '0) begin
            r = v;
        end else if (v == sign_bit) begin
            r = sign_bit - MAX_SAMPLE_W'(1);
        end else begin
            r = ((~v) + MAX_SAMPLE_W'(1)) & mask;
        end
        return r;
    endfunction

endpackage

// File: rtl/audio_interval_stats_stream_chan_min_max.sv
// chan_min_max
//   Running signed min/max register pair for one audio channel.
//   Ports:
//     clk, reset_n      : clock, asynchronous active-low reset
//     load              : first beat of an interval; min = max = sample
//     update            : later beat; fold sample into min/max (signed)
//     sample            : this channel's sample of the current frame
//     nxt_min, nxt_max  : values the registers take at the next edge
//                         (equal to the held values when neither control
//                         is high), so the parent can capture an interval
//                         result that already includes the current beat.
//   load has priority over update; with neither set the pair holds.

module chan_min_max
    import audio_stats_pkg::*;
#(
    parameter int SAMPLE_W = DEF_SAMPLE_W
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                load,
    input  logic                update,
    input  logic [SAMPLE_W-1:0] sample,
    output logic [SAMPLE_W-1:0] nxt_min,
    output logic [SAMPLE_W-1:0] nxt_max
);

    logic [SAMPLE_W-1:0] cur_min;
    logic [SAMPLE_W-1:0] cur_max;

    always_comb begin
        nxt_min = cur_min;
        nxt_max = cur_max;
        if (load) begin
            nxt_min = sample;
            nxt_max = sample;
        end else if (update) begin
            if ($signed(sample) < $signed(cur_min)) begin
                nxt_min = sample;
            end
            if ($signed(sample) > $signed(cur_max)) begin
                nxt_max = sample;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_min <= '0;
            cur_max <= '0;
        end else if (load || update) begin
            cur_min <= nxt_min;
            cur_max <= nxt_max;
        end
    end

endmodule

// File: rtl/audio_interval_stats_stream.sv
// audio_interval_stats_stream
//   Streaming per-channel signed min/max over runtime-programmable intervals.
//   Frames arrive on a valid/ready stream, one result beat per interval
//   leaves on a valid/ready stream. No sample storage: each channel keeps
//   only a running min/max pair (chan_min_max).
//
//   Handshake rule (both streams): a beat transfers on a rising clk edge
//   where valid and ready are both high; a source holds valid and its data
//   stable until that edge, and ready never depends combinationally on
//   valid.
//
//   Ports:
//     clk, reset_n   : clock, asynchronous active-low reset
//     start          : pulse, begins a run (IDLE only); samples interval_len
//     stop           : pulse, ends the run after flushing a partial interval
//     interval_len   : frames per interval, 0 behaves as 1
//     s_valid/s_ready/s_data : input frames, channel c at [c*SAMPLE_W +: SAMPLE_W]
//     m_valid/m_ready        : result stream
//     m_max, m_min   : per-channel interval max / min, packed like s_data
//     m_index        : interval number within the run (wraps)
//     m_partial      : interval closed by stop before interval_len frames
//     m_peak         : (AUDIO_STATS_PEAK_EN only) per-channel max(|min|,|max|)
//     busy           : state != IDLE
//     dbg_state      : controller state
//
//   Optional feature macro: AUDIO_STATS_PEAK_EN adds the m_peak output.

module audio_interval_stats_stream
    import audio_stats_pkg::*;
#(
    parameter int SAMPLE_W = DEF_SAMPLE_W,
    parameter int NUM_CH   = DEF_NUM_CH,
    parameter int LEN_W    = DEF_LEN_W,
    parameter int IDX_W    = DEF_IDX_W
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic                       stop,
    input  logic [LEN_W-1:0]           interval_len,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [NUM_CH*SAMPLE_W-1:0] s_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [NUM_CH*SAMPLE_W-1:0] m_max,
    output logic [NUM_CH*SAMPLE_W-1:0] m_min,
    output logic [IDX_W-1:0]           m_index,
    output logic                       m_partial,
`ifdef AUDIO_STATS_PEAK_EN
    output logic [NUM_CH*SAMPLE_W-1:0] m_peak,
`endif
    output logic                       busy,
    output state_t                     dbg_state
);

    localparam int FRAME_W = NUM_CH * SAMPLE_W;

    state_t           state;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] count;
    logic [IDX_W-1:0] index;
    logic             stop_pending;

    logic             accept;
    logic             closing;
    logic             ch_load;
    logic             ch_update;

    logic [FRAME_W-1:0] nxt_min_all;
    logic [FRAME_W-1:0] nxt_max_all;
`ifdef AUDIO_STATS_PEAK_EN
    logic [FRAME_W-1:0] nxt_peak_all;
`endif

    // Ready is a pure function of the registered state, so it never
    // depends on s_valid.
    assign s_ready   = (state == ACCUM);
    assign busy      = (state != IDLE);
    assign dbg_state = state;

    assign accept    = s_valid && s_ready;
    // len_q is never 0 in ACCUM, so len_q-1 cannot underflow here.
    assign closing   = accept && (count == (len_q - LEN_W'(1)));
    // The first beat of an interval loads instead of comparing, so no
    // sentinel min/max values are needed.
    assign ch_load   = accept && (count == '0);
    assign ch_update = accept && (count != '0);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [SAMPLE_W-1:0] sample;

        assign sample = SAMPLE_W'(extract_ch(MAX_FRAME_W'(s_data), c, SAMPLE_W));

        chan_min_max #(
            .SAMPLE_W (SAMPLE_W)
        ) u_chan (
            .clk     (clk),
            .reset_n (reset_n),
            .load    (ch_load),
            .update  (ch_update),
            .sample  (sample),
            .nxt_min (nxt_min_all[c*SAMPLE_W +: SAMPLE_W]),
            .nxt_max (nxt_max_all[c*SAMPLE_W +: SAMPLE_W])
        );

`ifdef AUDIO_STATS_PEAK_EN
        logic [SAMPLE_W-1:0] abs_min;
        logic [SAMPLE_W-1:0] abs_max;

        assign abs_min = SAMPLE_W'(abs_sat(MAX_SAMPLE_W'(nxt_min_all[c*SAMPLE_W +: SAMPLE_W]), SAMPLE_W));
        assign abs_max = SAMPLE_W'(abs_sat(MAX_SAMPLE_W'(nxt_max_all[c*SAMPLE_W +: SAMPLE_W]), SAMPLE_W));
        assign nxt_peak_all[c*SAMPLE_W +: SAMPLE_W] = (abs_min > abs_max) ? abs_min : abs_max;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            len_q        <= '0;
            count        <= '0;
            index        <= '0;
            stop_pending <= 1'b0;
            m_valid      <= 1'b0;
            m_partial    <= 1'b0;
            m_max        <= '0;
            m_min        <= '0;
            m_index      <= '0;
`ifdef AUDIO_STATS_PEAK_EN
            m_peak       <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        len_q        <= (interval_len == '0) ? LEN_W'(1) : interval_len;
                        count        <= '0;
                        index        <= '0;
                        stop_pending <= 1'b0;
                        state        <= ACCUM;
                    end
                end

                ACCUM: begin
                    if (accept) begin
                        count <= count + LEN_W'(1);
                    end
                    // A closing beat wins over stop: the interval is full,
                    // so it is reported as a normal result and stop only
                    // decides where the controller goes after the handshake.
                    // Otherwise stop flushes whatever has been gathered,
                    // including a beat accepted on the same cycle.
                    if (closing || (stop && (accept || count != '0))) begin
                        m_max        <= nxt_max_all;
                        m_min        <= nxt_min_all;
                        m_index      <= index;
                        m_partial    <= !closing;
`ifdef AUDIO_STATS_PEAK_EN
                        m_peak       <= nxt_peak_all;
`endif
                        m_valid      <= 1'b1;
                        stop_pending <= stop;
                        state        <= EMIT;
                    end else if (stop) begin
                        state <= IDLE;
                    end
                end

                EMIT: begin
                    if (m_ready) begin
                        m_valid      <= 1'b0;
                        index        <= index + IDX_W'(1);
                        count        <= '0;
                        stop_pending <= 1'b0;
                        // A stop landing on the handshake cycle itself is
                        // honoured as well, rather than being lost.
                        state        <= (stop_pending || stop) ? IDLE : ACCUM;
                    end else if (stop) begin
                        stop_pending <= 1'b1;
                    end
                end

                default: begin
                    state   <= IDLE;
                    m_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_audio_interval_stats_stream.sv
module tb_audio_interval_stats_stream;
    import audio_stats_pkg::*;

    localparam int SW      = 32;
    localparam int NCH     = 2;
    localparam int LW      = 16;
    localparam int IW      = 16;
    localparam int FW      = NCH * SW;
    localparam int EXP_W   = 2 * FW + IW + 1;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    always #5 clk = ~clk;

    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [LW-1:0] interval_len = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [FW-1:0] s_data = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [FW-1:0] m_max;
    logic [FW-1:0] m_min;
    logic [IW-1:0] m_index;
    logic          m_partial;
    logic          busy;
    state_t        dbg_state;
`ifdef AUDIO_STATS_PEAK_EN
    logic [FW-1:0] m_peak;
`endif

    audio_interval_stats_stream #(
        .SAMPLE_W (SW),
        .NUM_CH   (NCH),
        .LEN_W    (LW),
        .IDX_W    (IW)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .stop         (stop),
        .interval_len (interval_len),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_max        (m_max),
        .m_min        (m_min),
        .m_index      (m_index),
        .m_partial    (m_partial),
`ifdef AUDIO_STATS_PEAK_EN
        .m_peak       (m_peak),
`endif
        .busy         (busy),
        .dbg_state    (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_cmp  = 0;
    int n_fail = 0;
    logic [EXP_W-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    function automatic logic [EXP_W-1:0] pack_exp(
        input logic [31:0] max0, input logic [31:0] min0,
        input logic [31:0] max1, input logic [31:0] min1,
        input logic [IW-1:0] idx, input logic partial
    );
        return {max1, max0, min1, min0, idx, partial};
    endfunction

`ifdef AUDIO_STATS_PEAK_EN
    function automatic logic [31:0] ref_abs(input logic [31:0] v);
        if (v == 32'h8000_0000) return 32'h7FFF_FFFF;
        if (v[31]) return (~v) + 32'd1;
        return v;
    endfunction

    function automatic logic [31:0] ref_peak(input logic [31:0] mx, input logic [31:0] mn);
        logic [31:0] a;
        logic [31:0] b;
        a = ref_abs(mx);
        b = ref_abs(mn);
        return (a > b) ? a : b;
    endfunction
`endif

    // Result monitor: every output handshake is compared against the head
    // of the expected queue.
    always @(negedge clk) begin
        if (reset_n && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_result: got %h want none", {m_max, m_min, m_index, m_partial});
            end else begin
                logic [EXP_W-1:0] e;
                e = exp_q.pop_front();
                n_cmp++;
                if ({m_max, m_min, m_index, m_partial} !== e) begin
                    n_fail++;
                    $display("FAIL result: got %h want %h", {m_max, m_min, m_index, m_partial}, e);
                end
`ifdef AUDIO_STATS_PEAK_EN
                n_cmp++;
                if (m_peak !== {ref_peak(e[144:113], e[80:49]), ref_peak(e[112:81], e[48:17])}) begin
                    n_fail++;
                    $display("FAIL peak: got %h want %h", m_peak,
                             {ref_peak(e[144:113], e[80:49]), ref_peak(e[112:81], e[48:17])});
                end
`endif
            end
        end
    end

    // ---------------- driver tasks ----------------
    // All drivers start and end at posedge + 1.
    task automatic pulse_start(input logic [LW-1:0] len);
        interval_len = len;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] d0, input logic [31:0] d1, input logic with_stop);
        int k;
        s_valid = 1'b1;
        s_data  = {d1, d0};
        stop    = with_stop;
        k = 0;
        @(negedge clk);
        while (!s_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("s_ready_wait", 64'(s_ready), 64'd1);
        @(posedge clk); #1;
        s_valid = 1'b0;
        stop    = 1'b0;
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("busy_clear", 64'(busy), 64'd0);
        @(posedge clk); #1;
    endtask

    // Holds each result for 5 cycles, checking stall behaviour, then
    // accepts it.
    task automatic bp_responder(input int n_results);
        for (int r = 0; r < n_results; r++) begin
            int k;
            logic [EXP_W-1:0] snap;
            k = 0;
            @(negedge clk);
            while (!m_valid && k < 200) begin
                @(negedge clk);
                k++;
            end
            check("bp_m_valid_wait", 64'(m_valid), 64'd1);
            snap = {m_max, m_min, m_index, m_partial};
            for (int i = 0; i < 5; i++) begin
                if (i > 0) @(negedge clk);
                check("bp_s_ready_low", 64'(s_ready), 64'd0);
                n_cmp++;
                if ({m_valid, m_max, m_min, m_index, m_partial} !== {1'b1, snap}) begin
                    n_fail++;
                    $display("FAIL bp_stable: got %h want %h", {m_valid, m_max, m_min, m_index, m_partial}, {1'b1, snap});
                end
            end
            @(posedge clk); #1;
            m_ready = 1'b1;
            @(posedge clk); #1;
            m_ready = 1'b0;
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [LW-1:0] len;
        int            n;
        logic [31:0]   c0[5];
        logic [31:0]   c1[5];
        logic [31:0]   max0;
        logic [31:0]   min0;
        logic [31:0]   max1;
        logic [31:0]   min1;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0].len = 16'd4; vecs[0].n = 4;
        vecs[0].c0 = '{32'd5, -32'sd3, 32'd7, 32'd0, 32'd0};
        vecs[0].c1 = '{-32'sd1, -32'sd1, -32'sd1, -32'sd1, 32'd0};
        vecs[0].max0 = 32'd7;        vecs[0].min0 = -32'sd3;
        vecs[0].max1 = -32'sd1;      vecs[0].min1 = -32'sd1;

        vecs[1].len = 16'd2; vecs[1].n = 2;
        vecs[1].c0 = '{32'h8000_0000, 32'h7FFF_FFFF, 32'd0, 32'd0, 32'd0};
        vecs[1].c1 = '{32'h7FFF_FFFF, 32'h8000_0000, 32'd0, 32'd0, 32'd0};
        vecs[1].max0 = 32'h7FFF_FFFF; vecs[1].min0 = 32'h8000_0000;
        vecs[1].max1 = 32'h7FFF_FFFF; vecs[1].min1 = 32'h8000_0000;

        vecs[2].len = 16'd0; vecs[2].n = 1;
        vecs[2].c0 = '{-32'sd5, 32'd0, 32'd0, 32'd0, 32'd0};
        vecs[2].c1 = '{32'd9, 32'd0, 32'd0, 32'd0, 32'd0};
        vecs[2].max0 = -32'sd5;      vecs[2].min0 = -32'sd5;
        vecs[2].max1 = 32'd9;        vecs[2].min1 = 32'd9;

        vecs[3].len = 16'd5; vecs[3].n = 5;
        vecs[3].c0 = '{-32'sd100, -32'sd200, 32'd50, -32'sd300, 32'd49};
        vecs[3].c1 = '{32'd0, 32'd1, -32'sd1, 32'd2, -32'sd2};
        vecs[3].max0 = 32'd50;       vecs[3].min0 = -32'sd300;
        vecs[3].max1 = 32'd2;        vecs[3].min1 = -32'sd2;

        vecs[4].len = 16'd3; vecs[4].n = 3;
        vecs[4].c0 = '{-32'sd1, 32'd0, 32'd1, 32'd0, 32'd0};
        vecs[4].c1 = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0001, 32'd0, 32'd0};
        vecs[4].max0 = 32'd1;        vecs[4].min0 = -32'sd1;
        vecs[4].max1 = 32'h8000_0001; vecs[4].min1 = 32'h8000_0000;
    end

    // ---------------- test sequence ----------------
    initial begin
        // Reset state
        #12;
        check("rst_s_ready", 64'(s_ready), 64'd0);
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_m_partial", 64'(m_partial), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_state", 64'(dbg_state), 64'd0);
        check("rst_m_max", m_max, 64'd0);
        check("rst_m_min", m_min, 64'd0);
        check("rst_m_index", 64'(m_index), 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Table: one full interval per run, m_ready held high
        m_ready = 1'b1;
        for (int v = 0; v < 5; v++) begin
            pulse_start(vecs[v].len);
            check("busy_after_start", 64'(busy), 64'd1);
            exp_q.push_back(pack_exp(vecs[v].max0, vecs[v].min0, vecs[v].max1, vecs[v].min1, '0, 1'b0));
            for (int f = 0; f < vecs[v].n; f++) begin
                send_frame(vecs[v].c0[f], vecs[v].c1[f], 1'b0);
                // Result appears exactly one cycle after the closing beat.
                check("latency_m_valid", 64'(m_valid), (f == vecs[v].n - 1) ? 64'd1 : 64'd0);
            end
            wait_drain();
            pulse_stop();
            wait_idle();
        end

        // Back-pressure: len 3, 9 frames, each result stalled 5 cycles
        m_ready = 1'b0;
        pulse_start(16'd3);
        exp_q.push_back(pack_exp(32'd3, 32'd1, -32'sd1, -32'sd3, 16'd0, 1'b0));
        exp_q.push_back(pack_exp(32'd6, 32'd4, -32'sd4, -32'sd6, 16'd1, 1'b0));
        exp_q.push_back(pack_exp(32'd9, 32'd7, -32'sd7, -32'sd9, 16'd2, 1'b0));
        fork
            begin
                for (int f = 1; f <= 9; f++) send_frame(32'(f), 32'(-f), 1'b0);
            end
            bp_responder(3);
        join
        wait_drain();
        m_ready = 1'b1;
        pulse_stop();
        wait_idle();

        // Stop after 2 of 5 frames: partial result, then idle
        pulse_start(16'd5);
        exp_q.push_back(pack_exp(32'd20, 32'd10, 32'd3, -32'sd7, 16'd0, 1'b1));
        send_frame(32'd10, -32'sd7, 1'b0);
        send_frame(32'd20, 32'd3, 1'b0);
        pulse_stop();
        wait_drain();
        wait_idle();

        // Stop on a non-closing beat: that beat is included in the partial
        pulse_start(16'd5);
        exp_q.push_back(pack_exp(32'd2, 32'd1, 32'd0, -32'sd4, 16'd0, 1'b1));
        send_frame(32'd1, -32'sd4, 1'b0);
        send_frame(32'd2, 32'd0, 1'b1);
        wait_drain();
        wait_idle();

        // Stop on the closing beat: normal result, then idle
        pulse_start(16'd5);
        exp_q.push_back(pack_exp(32'd5, 32'd1, -32'sd1, -32'sd5, 16'd0, 1'b0));
        for (int f = 1; f <= 5; f++) send_frame(32'(f), 32'(-f), (f == 5));
        wait_drain();
        wait_idle();

        // Stop with count 0: straight to idle, no result beat
        pulse_start(16'd3);
        pulse_stop();
        wait_idle();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_output_after_empty_stop", 64'(m_valid), 64'd0);
        end
        @(posedge clk); #1;

        // interval_len 0: every frame is its own interval
        pulse_start(16'd0);
        exp_q.push_back(pack_exp(32'd11, 32'd11, -32'sd11, -32'sd11, 16'd0, 1'b0));
        exp_q.push_back(pack_exp(32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 16'd1, 1'b0));
        exp_q.push_back(pack_exp(32'd0, 32'd0, 32'd33, 32'd33, 16'd2, 1'b0));
        send_frame(32'd11, -32'sd11, 1'b0);
        send_frame(32'h8000_0000, 32'h7FFF_FFFF, 1'b0);
        send_frame(32'd0, 32'd33, 1'b0);
        wait_drain();
        pulse_stop();
        wait_idle();

        // Async reset in the middle of EMIT
        m_ready = 1'b0;
        pulse_start(16'd2);
        send_frame(32'd1, 32'd2, 1'b0);
        send_frame(32'd3, 32'd4, 1'b0);
        @(negedge clk);
        check("pre_reset_m_valid", 64'(m_valid), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_m_valid", 64'(m_valid), 64'd0);
        check("async_rst_busy", 64'(busy), 64'd0);
        check("async_rst_state", 64'(dbg_state), 64'd0);
        check("async_rst_s_ready", 64'(s_ready), 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("s_ready_before_start", 64'(s_ready), 64'd0);
        end
        @(posedge clk); #1;
        m_ready = 1'b1;
        pulse_start(16'd2);
        check("s_ready_after_start", 64'(s_ready), 64'd1);
        pulse_stop();
        wait_idle();

        check("exp_q_empty_at_end", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
